mem_access_unit: RTL

Multi-cycle memory bus interface that sits directly downstream of the accumulator processor's control unit. It accepts one instruction-fetch or data read/write request at a time and drives a handshaked external memory (chip-select/acknowledge). Read data is captured into an instruction-register or memory-data-register output, and `busy` is returned so the control FSM can stall until `done`.

---
 rtl/mem_access_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding memory bus interface with ack timeout
module mem_access_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic              req_kind,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] ir_out,
    output logic [DATA_W-1:0] mdr_out,
    output logic              error,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE,
        S_ERR
    } state_t;

    // Wait counter value seen during the last permitted BUSY cycle.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic       write_q;
    logic       kind_q;

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; an ack in the final BUSY cycle beats the timeout.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (req_valid) state_next = S_BUSY;
            S_BUSY: begin
                if (mem_ack) begin
                    state_next = S_DONE;
                end else if (wait_cnt == LAST_CNT) begin
                    state_next = S_ERR;
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Request latching, wait counting, read capture and sticky error flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt  <= 8'd0;
            write_q   <= 1'b0;
            kind_q    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ir_out    <= '0;
            mdr_out   <= '0;
            error     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        mem_addr  <= req_addr;
                        mem_wdata <= req_wdata;
                        write_q   <= req_write;
                        kind_q    <= req_kind;
                        wait_cnt  <= 8'd0;
                    end
                end
                S_BUSY: begin
                    if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                    if (mem_ack) begin
                        if (!write_q) begin
                            if (kind_q) begin
                                ir_out <= mem_rdata;
                            end else begin
                                mdr_out <= mem_rdata;
                            end
                        end
                    end else if (wait_cnt == LAST_CNT) begin
                        error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE) || (state == S_ERR);
    assign mem_cs    = (state == S_BUSY);
    assign mem_we    = (state == S_BUSY) && write_q;

endmodule
